// File: rtl/maxnet_controller.sv
// -----------------------------------------------------------------------------
// maxnet_controller
//
// Sequencer for a fixed-weight competitive (MAXNET) network datapath. It walks
// the shared input/weight memory and the single MAC unit through every
// neuron's weighted sum, one iteration at a time. It stops when at most one
// neuron is still positive, or when MAX_ITER iterations have completed. It
// drives addresses and strobes only and never sees data words.
//
// Parameters:
//   N        number of neurons/inputs (power of two, >= 2)
//   MAX_ITER iteration limit (>= 1, < 2**IW)
//   IW       iteration counter width
//   AW, XW   derived address widths (log2(N*N), log2(N)); leave at default
//
// Ports:
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   start       begin a run (only looked at in IDLE)
//   pos_flag    accumulator result > 0 (sampled at the WRITE edge)
//   busy        high from the first LOAD cycle through the DONE cycle
//   done        one-cycle pulse in DONE
//   converged   1 = at most one positive neuron, 0 = limit hit; held to next start
//   load_en     copy input word x_addr into feedback register x_addr
//   acc_clr     clear accumulator
//   acc_en      accumulate W[w_addr] * Xfb[x_addr]
//   out_we      write clamped accumulator to next-state register out_addr
//   commit      copy next-state registers into feedback registers
//   w_addr      weight index, row*N + col
//   x_addr      input/feedback index
//   out_addr    neuron being written
//   iter        completed iterations
// -----------------------------------------------------------------------------
module maxnet_controller #(
   parameter int N        = 4,
   parameter int MAX_ITER = 15,
   parameter int IW       = 8,
   parameter int AW       = $clog2(N * N),
   parameter int XW       = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          pos_flag,
   output logic          busy,
   output logic          done,
   output logic          converged,
   output logic          load_en,
   output logic          acc_clr,
   output logic          acc_en,
   output logic          out_we,
   output logic          commit,
   output logic [AW-1:0] w_addr,
   output logic [XW-1:0] x_addr,
   output logic [XW-1:0] out_addr,
   output logic [IW-1:0] iter
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CLEAR,
      S_MAC,
      S_WRITE,
      S_CHECK,
      S_COMMIT,
      S_DONE
   } state_t;

   localparam logic [XW-1:0] LAST_IDX   = XW'(N - 1);
   localparam logic [IW-1:0] ITER_LIMIT = IW'(MAX_ITER);
   localparam logic [1:0]    PC_SAT     = 2'd2;

   state_t        state_q, state_d;
   logic [XW-1:0] i_q, i_d;          // column / input index
   logic [XW-1:0] j_q, j_d;          // neuron (row) index
   logic [1:0]    pc_q, pc_d;        // positive count, saturating at 2
   logic [IW-1:0] iter_q, iter_d;
   logic          converged_q, converged_d;

   // Every output is a flop; its _d value is decoded from the next state.
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          load_en_q, load_en_d;
   logic          acc_clr_q, acc_clr_d;
   logic          acc_en_q, acc_en_d;
   logic          out_we_q, out_we_d;
   logic          commit_q, commit_d;
   logic [AW-1:0] w_addr_q, w_addr_d;
   logic [XW-1:0] x_addr_q, x_addr_d;
   logic [XW-1:0] out_addr_q, out_addr_d;

   // Next-state and counter logic.
   always_comb begin
      // NOTE: every variable gets a default before the case so that no path
      // leaves it unassigned; an unassigned path would infer a latch.
      state_d     = state_q;
      i_d         = i_q;
      j_d         = j_q;
      pc_d        = pc_q;
      iter_d      = iter_q;
      converged_d = converged_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_LOAD;
               i_d         = '0;
               j_d         = '0;
               pc_d        = '0;
               iter_d      = '0;
               converged_d = 1'b0;
            end
         end

         S_LOAD: begin
            if (i_q == LAST_IDX) begin
               state_d = S_CLEAR;
               i_d     = '0;
            end else begin
               i_d = i_q + 1'b1;
            end
         end

         S_CLEAR: begin
            state_d = S_MAC;
            i_d     = '0;
         end

         S_MAC: begin
            if (i_q == LAST_IDX) begin
               state_d = S_WRITE;
               i_d     = '0;
            end else begin
               i_d = i_q + 1'b1;
            end
         end

         S_WRITE: begin
            // Only "at most one" versus "more than one" matters, so stop at 2.
            if (pos_flag && (pc_q != PC_SAT)) begin
               pc_d = pc_q + 2'd1;
            end
            if (j_q != LAST_IDX) begin
               j_d     = j_q + 1'b1;
               state_d = S_CLEAR;
            end else begin
               state_d = S_CHECK;
            end
         end

         S_CHECK: begin
            // pc_q already includes the last neuron's WRITE.
            iter_d = iter_q + 1'b1;
            if (pc_q <= 2'd1) begin
               converged_d = 1'b1;
               state_d     = S_DONE;
            end else if (iter_d == ITER_LIMIT) begin
               converged_d = 1'b0;
               state_d     = S_DONE;
            end else begin
               state_d = S_COMMIT;
            end
         end

         S_COMMIT: begin
            j_d     = '0;
            pc_d    = '0;
            state_d = S_CLEAR;
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode from the upcoming state, so the strobes are registered and
   // line up with the state they belong to. Unused addresses are driven to 0.
   always_comb begin
      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_DONE);
      load_en_d  = (state_d == S_LOAD);
      acc_clr_d  = (state_d == S_CLEAR);
      acc_en_d   = (state_d == S_MAC);
      out_we_d   = (state_d == S_WRITE);
      commit_d   = (state_d == S_COMMIT);
      x_addr_d   = ((state_d == S_LOAD) || (state_d == S_MAC)) ? i_d : '0;
      // N is a power of two, so row*N + col is a plain concatenation.
      w_addr_d   = (state_d == S_MAC) ? {j_d, i_d} : '0;
      out_addr_d = (state_d == S_WRITE) ? j_d : '0;
   end

   // NOTE: sequential state uses non-blocking assignments so that every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         i_q         <= '0;
         j_q         <= '0;
         pc_q        <= '0;
         iter_q      <= '0;
         converged_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         load_en_q   <= 1'b0;
         acc_clr_q   <= 1'b0;
         acc_en_q    <= 1'b0;
         out_we_q    <= 1'b0;
         commit_q    <= 1'b0;
         w_addr_q    <= '0;
         x_addr_q    <= '0;
         out_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         i_q         <= i_d;
         j_q         <= j_d;
         pc_q        <= pc_d;
         iter_q      <= iter_d;
         converged_q <= converged_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         load_en_q   <= load_en_d;
         acc_clr_q   <= acc_clr_d;
         acc_en_q    <= acc_en_d;
         out_we_q    <= out_we_d;
         commit_q    <= commit_d;
         w_addr_q    <= w_addr_d;
         x_addr_q    <= x_addr_d;
         out_addr_q  <= out_addr_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign converged = converged_q;
   assign load_en   = load_en_q;
   assign acc_clr   = acc_clr_q;
   assign acc_en    = acc_en_q;
   assign out_we    = out_we_q;
   assign commit    = commit_q;
   assign w_addr    = w_addr_q;
   assign x_addr    = x_addr_q;
   assign out_addr  = out_addr_q;
   assign iter      = iter_q;

endmodule
